// File: rtl/sar_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : sar_pkg                                                  |
// | Description : Shared state encoding, default sizing and timer helper   |
// |               for the SAR conversion controller.                       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package sar_pkg;

  localparam int c_n_bits     = 8;
  localparam int c_sample_cyc = 4;
  localparam int c_settle_cyc = 2;

  typedef logic [2:0] sar_state_t;

  localparam sar_state_t c_st_idle   = 3'd0;
  localparam sar_state_t c_st_sample = 3'd1;
  localparam sar_state_t c_st_settle = 3'd2;
  localparam sar_state_t c_st_decide = 3'd3;
  localparam sar_state_t c_st_done   = 3'd4;

  // Timer only ever holds (cycles - 1), so the larger phase length sets the width.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sar_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : sar_timer                                                |
// | Description : Loadable down-counter with zero flag; times the SAMPLE   |
// |               and SETTLE phases of the SAR controller.                 |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module sar_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/sar_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : sar_ctrl                                                 |
// | Description : Successive-approximation ADC controller. Defining        |
// |               SAR_AVG_EN averages four back-to-back conversions.       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module sar_ctrl
  import sar_pkg::*;
#(
  parameter int N_BITS     = c_n_bits,
  parameter int SAMPLE_CYC = c_sample_cyc,
  parameter int SETTLE_CYC = c_settle_cyc
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              comp_i,
  input  logic              ready_i,
  output logic              sample_o,
  output logic [N_BITS-1:0] dac_o,
  output logic [N_BITS-1:0] result_o,
  output logic              valid_o,
  output logic              busy_o
);

  localparam int c_tw = timer_width(SAMPLE_CYC, SETTLE_CYC);
  localparam int c_iw = $clog2(N_BITS);

  localparam logic [c_tw-1:0] c_sample_ld = c_tw'(SAMPLE_CYC - 1);
  localparam logic [c_tw-1:0] c_settle_ld = c_tw'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  // With no settle time a new trial code goes straight to DECIDE.
  localparam sar_state_t      c_trial_st  = (SETTLE_CYC > 0) ? c_st_settle : c_st_decide;
  localparam logic [c_iw-1:0] c_msb_idx   = c_iw'(N_BITS - 1);

  sar_state_t        r_state;
  sar_state_t        w_state_nxt;
  logic [c_iw-1:0]   r_bit_idx;
  logic [c_iw-1:0]   w_idx_dec;
  logic [N_BITS-1:0] r_sar;
  logic [N_BITS-1:0] r_dac;
  logic [N_BITS-1:0] r_result;
  logic [N_BITS-1:0] w_sar_new;
  logic [N_BITS-1:0] w_next_mask;
  logic              w_abort;
  logic              w_last_conv;
  logic              w_tmr_load;
  logic [c_tw-1:0]   w_tmr_val;
  logic              w_tmr_zero;

`ifdef SAR_AVG_EN
  logic [1:0]        r_conv;
  logic [N_BITS+1:0] r_sum;
  logic [N_BITS+1:0] w_sum_new;

  assign w_last_conv = (r_conv == 2'd3);
  assign w_sum_new   = r_sum + {2'b00, w_sar_new};
`else
  assign w_last_conv = 1'b1;
`endif

  assign w_abort     = abort_i && (r_state != c_st_idle);
  assign w_sar_new   = comp_i ? r_dac : r_sar;
  assign w_idx_dec   = r_bit_idx - c_iw'(1);
  assign w_next_mask = N_BITS'(1) << w_idx_dec;

  sar_timer #(
    .WIDTH (c_tw)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = c_sample_ld;
    case (r_state)
      c_st_idle: begin
        if (start_i && !abort_i) begin
          w_state_nxt = c_st_sample;
          w_tmr_load  = 1'b1;
        end
      end
      c_st_sample: begin
        if (w_tmr_zero) begin
          w_state_nxt = c_trial_st;
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_settle_ld;
        end
      end
      c_st_settle: begin
        if (w_tmr_zero) w_state_nxt = c_st_decide;
      end
      c_st_decide: begin
        if (r_bit_idx != '0) begin
          w_state_nxt = c_trial_st;
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_settle_ld;
        end else if (w_last_conv) begin
          w_state_nxt = c_st_done;
        end else begin
          w_state_nxt = c_st_sample;
          w_tmr_load  = 1'b1;
        end
      end
      c_st_done: begin
        if (ready_i) w_state_nxt = c_st_idle;
      end
      default: w_state_nxt = c_st_idle;
    endcase
    if (w_abort) begin
      w_state_nxt = c_st_idle;
      w_tmr_load  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_abort) begin
      r_state   <= c_st_idle;
      r_bit_idx <= '0;
      r_sar     <= '0;
      r_dac     <= '0;
      r_result  <= '0;
`ifdef SAR_AVG_EN
      r_conv    <= '0;
      r_sum     <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        c_st_sample: begin
          if (w_tmr_zero) begin
            r_bit_idx <= c_msb_idx;
            r_sar     <= '0;
            r_dac     <= N_BITS'(1) << c_msb_idx;
          end
        end
        c_st_decide: begin
          r_sar <= w_sar_new;
          if (r_bit_idx != '0) begin
            r_bit_idx <= w_idx_dec;
            r_dac     <= w_sar_new | w_next_mask;
          end else begin
            r_dac <= '0;
`ifdef SAR_AVG_EN
            if (w_last_conv) begin
              r_result <= N_BITS'(w_sum_new >> 2);
              r_sum    <= '0;
              r_conv   <= '0;
            end else begin
              r_sum  <= w_sum_new;
              r_conv <= r_conv + 2'd1;
            end
`else
            r_result <= w_sar_new;
`endif
          end
        end
        c_st_done: begin
          if (ready_i) r_result <= '0;
        end
        default: ;
      endcase
    end
  end

  assign sample_o = (r_state == c_st_sample);
  assign valid_o  = (r_state == c_st_done);
  assign busy_o   = (r_state != c_st_idle);
  assign dac_o    = r_dac;
  assign result_o = valid_o ? r_result : '0;

endmodule
`default_nettype wire

// File: tb/tb_sar_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_sar_ctrl                                              |
// | Description : Directed self-checking bench for sar_ctrl with an ideal  |
// |               comparator model; honours SAR_AVG_EN.                    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_sar_ctrl;

`ifdef SAR_AVG_EN
  localparam int c_lat = 113;
`else
  localparam int c_lat = 29;
`endif
  localparam int c_max = 150;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic       abort_i;
  logic       comp_i;
  logic       ready_i;
  logic       sample_o;
  logic [7:0] dac_o;
  logic [7:0] result_o;
  logic       valid_o;
  logic       busy_o;
  logic [7:0] vin;
  logic [7:0] trials [8];

  int checks = 0;
  int errors = 0;

  sar_ctrl u_dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .abort_i  (abort_i),
    .comp_i   (comp_i),
    .ready_i  (ready_i),
    .sample_o (sample_o),
    .dac_o    (dac_o),
    .result_o (result_o),
    .valid_o  (valid_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  assign comp_i = (vin >= dac_o);

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_value({tag, "_sample"}, sample_o, 1'b0);
    check_value({tag, "_dac"},    dac_o,    8'h00);
    check_value({tag, "_result"}, result_o, 8'h00);
    check_value({tag, "_valid"},  valid_o,  1'b0);
    check_value({tag, "_busy"},   busy_o,   1'b0);
  endtask

  // Start in cycle 0, follow the conversion until valid_o, then optionally release it.
  task automatic run_conv(input logic [7:0] v, input logic [7:0] exp_res,
                          input bit chk_trials, input bit release_it);
    int cyc;
    int lat;
    vin     = v;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    cyc     = 1;
    lat     = -1;
    while (cyc <= c_max) begin
      if (chk_trials && cyc == 1) begin
        check_value("sample_first", sample_o, 1'b1);
        check_value("dac_in_sample", dac_o, 8'h00);
      end
      if (chk_trials && cyc == 4) check_value("sample_last", sample_o, 1'b1);
      if (chk_trials && cyc == 5) check_value("sample_off", sample_o, 1'b0);
      if (chk_trials && cyc >= 5 && cyc < 29 && ((cyc - 5) % 3) == 0)
        check_value($sformatf("trial%0d", (cyc - 5) / 3), dac_o, trials[(cyc - 5) / 3]);
      if (valid_o) begin
        lat = cyc;
        break;
      end
      tick();
      cyc++;
    end
    check_value("latency", lat, c_lat);
    check_value("result", result_o, exp_res);
    if (release_it) begin
      tick();
      check_value("released_valid", valid_o, 1'b0);
      check_value("released_busy", busy_o, 1'b0);
    end
  endtask

  initial begin
    int cyc;
    int seen;
    trials  = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    rst     = 1'b1;
    start_i = 1'b0;
    abort_i = 1'b0;
    ready_i = 1'b1;
    vin     = 8'h00;
    repeat (3) tick();
    check_quiet("reset");
    rst = 1'b0;
    tick();

    run_conv(8'hA5, 8'hA5, 1'b1, 1'b1);
    run_conv(8'h00, 8'h00, 1'b0, 1'b1);
    run_conv(8'hFF, 8'hFF, 1'b0, 1'b1);

    // Backpressure: hold ready low for 10 cycles with start pulses in DONE.
    ready_i = 1'b0;
    run_conv(8'h3C, 8'h3C, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      start_i = ~start_i;
      tick();
      check_value("bp_valid", valid_o, 1'b1);
      check_value("bp_result", result_o, 8'h3C);
    end
    start_i = 1'b0;
    ready_i = 1'b1;
    tick();
    check_value("bp_idle_busy", busy_o, 1'b0);
    check_value("bp_idle_valid", valid_o, 1'b0);
    tick();
    check_value("bp_no_restart", busy_o, 1'b0);

    // Abort in cycle 10.
    vin     = 8'h77;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    check_value("pre_abort_busy", busy_o, 1'b1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check_quiet("abort");
    seen = 0;
    for (int k = 0; k < c_lat + 10; k++) begin
      tick();
      if (valid_o || busy_o) seen++;
    end
    check_value("abort_no_valid", seen, 0);

    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    check_value("start_abort_idle", busy_o, 1'b0);
    tick();
    check_value("start_abort_idle2", busy_o, 1'b0);

    // Reset in cycle 15, then a clean conversion.
    vin     = 8'hC3;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (14) tick();
    check_value("pre_reset_busy", busy_o, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_quiet("midreset");
    run_conv(8'h5A, 8'h5A, 1'b0, 1'b1);

`ifdef SAR_AVG_EN
    // Four conversions of 28 cycles each, analog input changing per conversion.
    vin     = 8'h10;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    cyc     = 1;
    seen    = -1;
    while (cyc <= c_max) begin
      case ((cyc - 1) / 28)
        0:       vin = 8'h10;
        1:       vin = 8'h13;
        2:       vin = 8'h10;
        default: vin = 8'h13;
      endcase
      if (valid_o) begin
        seen = cyc;
        break;
      end
      tick();
      cyc++;
    end
    check_value("avg_latency", seen, 113);
    check_value("avg_result", result_o, 8'h11);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
